// File: rtl/vga_if.sv
// Pixel-side bundle of the VGA timing generator: drawing-stage colour in,
// scan position, blanking and registered DAC/sync signals out.
interface vga_if;
    logic [2:0] rgb_in;
    logic [9:0] col;
    logic [9:0] row;
    logic       visible;
    logic       pixel_tick;
    logic       frame_start;
    logic [2:0] rgb;
    logic       hsync;
    logic       vsync;

    modport master (
        input  rgb_in,
        output col, row, visible, pixel_tick, frame_start, rgb, hsync, vsync
    );

    modport slave (
        output rgb_in,
        input  col, row, visible, pixel_tick, frame_start, rgb, hsync, vsync
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing: clock divider, col/row scan counters, sync decode and a
// one-pixel registered output stage for colour and syncs.
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic  clk,
    input  logic  reset_n,
    vga_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_p0;
    logic [9:0]       col_p0;
    logic [9:0]       row_p0;
    logic             tick_p0;
    logic             line_end_p0;
    logic             frame_end_p0;
    logic             visible_p0;
    logic             hsync_d;
    logic             vsync_d;
    logic [2:0]       rgb_p1;
    logic             hsync_p1;
    logic             vsync_p1;
    logic             frame_p1;

    // Stage p0: divider and scan counters
    assign tick_p0      = reset_n && (div_p0 == DIV_LAST);
    assign line_end_p0  = (col_p0 == H_LAST);
    assign frame_end_p0 = line_end_p0 && (row_p0 == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_p0 <= '0;
        end else if (div_p0 == DIV_LAST) begin
            div_p0 <= '0;
        end else begin
            div_p0 <= div_p0 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (tick_p0) begin
            if (line_end_p0) begin
                col_p0 <= '0;
                row_p0 <= (row_p0 == V_LAST) ? 10'd0 : row_p0 + 10'd1;
            end else begin
                col_p0 <= col_p0 + 10'd1;
            end
        end
    end

    assign visible_p0 = ({1'b0, col_p0} < H_VIS) && ({1'b0, row_p0} < V_VIS);
    assign hsync_d    = !(({1'b0, col_p0} >= HS_BEG) && ({1'b0, col_p0} < HS_END));
    assign vsync_d    = !(({1'b0, row_p0} >= VS_BEG) && ({1'b0, row_p0} < VS_END));

    // Stage p1: colour and syncs registered one pixel behind col/row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_p1   <= 3'b000;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            frame_p1 <= 1'b0;
        end else begin
            frame_p1 <= tick_p0 && frame_end_p0;
            if (tick_p0) begin
                rgb_p1   <= visible_p0 ? vga.rgb_in : 3'b000;
                hsync_p1 <= hsync_d;
                vsync_p1 <= vsync_d;
            end
        end
    end

    assign vga.col         = col_p0;
    assign vga.row         = row_p0;
    assign vga.visible     = visible_p0;
    assign vga.pixel_tick  = tick_p0;
    assign vga.frame_start = frame_p1;
    assign vga.rgb         = rgb_p1;
    assign vga.hsync       = hsync_p1;
    assign vga.vsync       = vsync_p1;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size instance for line timing, plus two small
// rasters (CLK_DIV 2 and 1) checked cycle by cycle against an arithmetic scan model.
module tb_vga_timing;
    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_if vif_d ();
    vga_if vif_s ();
    vga_if vif_1 ();

    vga_timing dut_d (.clk(clk), .reset_n(reset_n), .vga(vif_d));
    vga_timing #(.CLK_DIV(2), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                 .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB))
        dut_s (.clk(clk), .reset_n(reset_n), .vga(vif_s));
    vga_timing #(.CLK_DIV(1), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                 .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB))
        dut_1 (.clk(clk), .reset_n(reset_n), .vga(vif_1));

    // clock edges seen since the last reset release
    int c;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) c <= 0;
        else          c <= c + 1;
    end

    int tests = 0;
    int fails = 0;

    int         sel = 0;
    logic [9:0] m_col, m_row;
    logic [2:0] m_rgb;
    logic       m_vis, m_tick, m_fs, m_hs, m_vs;
    always_comb begin
        if (sel == 0) begin
            m_col = vif_s.col; m_row = vif_s.row; m_rgb = vif_s.rgb; m_vis = vif_s.visible;
            m_tick = vif_s.pixel_tick; m_fs = vif_s.frame_start; m_hs = vif_s.hsync; m_vs = vif_s.vsync;
        end else begin
            m_col = vif_1.col; m_row = vif_1.row; m_rgb = vif_1.rgb; m_vis = vif_1.visible;
            m_tick = vif_1.pixel_tick; m_fs = vif_1.frame_start; m_hs = vif_1.hsync; m_vs = vif_1.vsync;
        end
    end

    // Scan model: after cc edges, cc/dv pixels have elapsed since (0,0)
    function automatic int e_col(int cc, int dv); return (cc / dv) % SHT; endfunction
    function automatic int e_row(int cc, int dv); return (cc / dv / SHT) % SVT; endfunction
    function automatic bit e_tick(int cc, int dv); return ((cc + 1) % dv) == 0; endfunction
    function automatic bit e_fs(int cc, int dv);
        return cc > 0 && (cc % dv) == 0 && ((cc / dv) % (SHT * SVT)) == 0;
    endfunction
    function automatic bit e_hs(int cc, int dv);
        int n = cc / dv;
        int p;
        if (n == 0) return 1'b1;
        p = (n - 1) % SHT;
        return !(p >= SHV + SHF && p < SHV + SHF + SHS);
    endfunction
    function automatic bit e_vs(int cc, int dv);
        int n = cc / dv;
        int r;
        if (n == 0) return 1'b1;
        r = ((n - 1) / SHT) % SVT;
        return !(r >= SVV + SVF && r < SVV + SVF + SVS);
    endfunction
    function automatic bit e_vis(int cl, int rw); return cl < SHV && rw < SVV; endfunction

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (vif_d.col !== 10'd0) begin fails++; $display("FAIL rst_col got %0d exp 0", vif_d.col); end
        tests++; if (vif_d.row !== 10'd0) begin fails++; $display("FAIL rst_row got %0d exp 0", vif_d.row); end
        tests++; if (vif_d.rgb !== 3'b000) begin fails++; $display("FAIL rst_rgb got %b exp 000", vif_d.rgb); end
        tests++; if (vif_d.hsync !== 1'b1) begin fails++; $display("FAIL rst_hsync got %b exp 1", vif_d.hsync); end
        tests++; if (vif_d.vsync !== 1'b1) begin fails++; $display("FAIL rst_vsync got %b exp 1", vif_d.vsync); end
        tests++; if (vif_d.frame_start !== 1'b0) begin fails++; $display("FAIL rst_fs got %b exp 0", vif_d.frame_start); end
        tests++; if (vif_d.pixel_tick !== 1'b0) begin fails++; $display("FAIL rst_tick got %b exp 0", vif_d.pixel_tick); end
        tests++; if (vif_1.pixel_tick !== 1'b0) begin fails++; $display("FAIL rst_tick_div1 got %b exp 0", vif_1.pixel_tick); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (vif_d.pixel_tick !== 1'b1) begin fails++; $display("FAIL first_tick got %b exp 1", vif_d.pixel_tick); end
        tests++; if (vif_d.col !== 10'd0) begin fails++; $display("FAIL first_tick_col0 got %0d exp 0", vif_d.col); end
        tests++; if (vif_1.col !== 10'd1) begin fails++; $display("FAIL div1_first_col got %0d exp 1", vif_1.col); end
        @(posedge clk); #1;
        tests++; if (vif_d.col !== 10'd1) begin fails++; $display("FAIL first_col got %0d exp 1", vif_d.col); end
        tests++; if (vif_d.pixel_tick !== 1'b0) begin fails++; $display("FAIL tick_after got %b exp 0", vif_d.pixel_tick); end
        tests++; if (vif_d.frame_start !== 1'b0) begin fails++; $display("FAIL release_fs got %b exp 0", vif_d.frame_start); end
    endtask

    task automatic test_hline;
        int guard = 0, lowcnt = 0, first_low = -1, c1 = -1, c2 = -1, prev_col = 0, wrap_prev = -1;
        vif_d.rgb_in = 3'b101;
        while (c2 < 0 && guard < 4000) begin
            @(posedge clk); #1; guard++;
            if (c1 < 0 && (c % 2) == 0 && vif_d.hsync == 1'b0) begin
                lowcnt++;
                if (first_low < 0) first_low = vif_d.col;
            end
            if (c1 < 0 && vif_d.col == 10'd0 && vif_d.row == 10'd1) begin c1 = c; wrap_prev = prev_col; end
            if (vif_d.col == 10'd0 && vif_d.row == 10'd2) c2 = c;
            prev_col = vif_d.col;
        end
        tests++; if (c2 < 0) begin fails++; $display("FAIL hline_timeout got %0d edges exp wrap to row 2", guard); end
        tests++; if (lowcnt != 96) begin fails++; $display("FAIL hsync_width got %0d exp 96", lowcnt); end
        tests++; if (first_low != 657) begin fails++; $display("FAIL hsync_first_col got %0d exp 657", first_low); end
        tests++; if (wrap_prev != 799) begin fails++; $display("FAIL hwrap_prev_col got %0d exp 799", wrap_prev); end
        tests++; if (c1 != 1600) begin fails++; $display("FAIL hwrap_clk got %0d exp 1600", c1); end
        tests++; if (c2 - c1 != 1600) begin fails++; $display("FAIL line_period got %0d exp 1600", c2 - c1); end
    endtask

    task automatic test_model(input int s, input int ncyc, input bit fixed);
        int dv = (s == 0) ? 2 : 1;
        int cpre, ec, er, nz = 0;
        logic [2:0] drv;
        logic [2:0] exp_rgb = 3'b000;
        bit known = 1'b0;
        sel = s;
        repeat (ncyc) begin
            @(negedge clk);
            drv = fixed ? 3'b101 : 3'($urandom_range(0, 7));
            vif_s.rgb_in = drv;
            vif_1.rgb_in = drv;
            cpre = c;
            @(posedge clk); #1;
            if (e_tick(cpre, dv)) begin
                exp_rgb = e_vis(e_col(cpre, dv), e_row(cpre, dv)) ? drv : 3'b000;
                known = 1'b1;
            end
            ec = e_col(c, dv);
            er = e_row(c, dv);
            tests++; if (m_col !== 10'(ec)) begin fails++; $display("FAIL m_col s%0d c=%0d got %0d exp %0d", s, c, m_col, ec); end
            tests++; if (m_row !== 10'(er)) begin fails++; $display("FAIL m_row s%0d c=%0d got %0d exp %0d", s, c, m_row, er); end
            tests++; if (m_tick !== e_tick(c, dv)) begin fails++; $display("FAIL m_tick s%0d c=%0d got %b exp %b", s, c, m_tick, e_tick(c, dv)); end
            tests++; if (m_fs !== e_fs(c, dv)) begin fails++; $display("FAIL m_fs s%0d c=%0d got %b exp %b", s, c, m_fs, e_fs(c, dv)); end
            tests++; if (m_hs !== e_hs(c, dv)) begin fails++; $display("FAIL m_hsync s%0d c=%0d got %b exp %b", s, c, m_hs, e_hs(c, dv)); end
            tests++; if (m_vs !== e_vs(c, dv)) begin fails++; $display("FAIL m_vsync s%0d c=%0d got %b exp %b", s, c, m_vs, e_vs(c, dv)); end
            tests++; if (m_vis !== e_vis(ec, er)) begin fails++; $display("FAIL m_visible s%0d c=%0d got %b exp %b", s, c, m_vis, e_vis(ec, er)); end
            if (known) begin
                tests++; if (m_rgb !== exp_rgb) begin fails++; $display("FAIL m_rgb s%0d c=%0d got %b exp %b", s, c, m_rgb, exp_rgb); end
            end
            if (m_rgb == 3'b101) nz++;
        end
        if (fixed) begin
            tests++; if (nz == 0) begin fails++; $display("FAIL blank_no_colour got %0d coloured clks exp >0", nz); end
        end
    endtask

    task automatic test_frame;
        int guard = 0, c0, vlow = 0, c1 = -1;
        while (!(vif_s.row == 10'(SVT - 1) && vif_s.col == 10'(SHT - 1) && vif_s.pixel_tick) && guard < 2000) begin
            @(posedge clk); #1; guard++;
        end
        tests++; if (guard >= 2000) begin fails++; $display("FAIL frame_wait_timeout got %0d edges exp last pixel", guard); end
        @(posedge clk); #1;
        c0 = c;
        tests++; if (vif_s.col !== 10'd0 || vif_s.row !== 10'd0) begin fails++; $display("FAIL fwrap_pos got %0d,%0d exp 0,0", vif_s.row, vif_s.col); end
        tests++; if (vif_s.frame_start !== 1'b1) begin fails++; $display("FAIL fs_pulse got %b exp 1", vif_s.frame_start); end
        @(posedge clk); #1;
        tests++; if (vif_s.frame_start !== 1'b0) begin fails++; $display("FAIL fs_width got %b exp 0", vif_s.frame_start); end
        if ((c % 2) == 0 && vif_s.vsync == 1'b0) vlow++;
        guard = 0;
        while (c1 < 0 && guard < 2000) begin
            @(posedge clk); #1; guard++;
            if ((c % 2) == 0 && vif_s.vsync == 1'b0) vlow++;
            if (vif_s.frame_start) c1 = c;
        end
        tests++; if (vlow != 2 * SHT) begin fails++; $display("FAIL vsync_width got %0d exp %0d", vlow, 2 * SHT); end
        tests++; if (c1 - c0 != 2 * SHT * SVT) begin fails++; $display("FAIL frame_period got %0d exp %0d", c1 - c0, 2 * SHT * SVT); end
    endtask

    task automatic test_div1;
        int guard = 0, c0, c1 = -1, lowcnt = 0, first_low = -1, miss = 0;
        while (vif_1.col != 10'd0 && guard < 100) begin @(posedge clk); #1; guard++; end
        c0 = c;
        guard = 0;
        while (c1 < 0 && guard < 100) begin
            @(posedge clk); #1; guard++;
            if (vif_1.pixel_tick !== 1'b1) miss++;
            if (vif_1.hsync == 1'b0) begin lowcnt++; if (first_low < 0) first_low = vif_1.col; end
            if (vif_1.col == 10'd0) c1 = c;
        end
        tests++; if (c1 - c0 != SHT) begin fails++; $display("FAIL div1_line_period got %0d exp %0d", c1 - c0, SHT); end
        tests++; if (miss != 0) begin fails++; $display("FAIL div1_tick_gaps got %0d exp 0", miss); end
        tests++; if (lowcnt != SHS) begin fails++; $display("FAIL div1_hsync_width got %0d exp %0d", lowcnt, SHS); end
        tests++; if (first_low != SHV + SHF + 1) begin fails++; $display("FAIL div1_hsync_col got %0d exp %0d", first_low, SHV + SHF + 1); end
    endtask

    task automatic test_midreset;
        int guard = 0;
        while (!(vif_s.row == 10'd10 && vif_s.col == 10'd20) && guard < 2000) begin @(posedge clk); #1; guard++; end
        tests++; if (guard >= 2000) begin fails++; $display("FAIL midrst_wait_timeout got %0d edges exp row10 col20", guard); end
        tests++; if (vif_s.hsync !== 1'b0 || vif_s.vsync !== 1'b0) begin fails++; $display("FAIL midrst_pre_sync got %b%b exp 00", vif_s.hsync, vif_s.vsync); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (vif_s.hsync !== 1'b1 || vif_s.vsync !== 1'b1) begin fails++; $display("FAIL midrst_sync got %b%b exp 11", vif_s.hsync, vif_s.vsync); end
        tests++; if (vif_s.col !== 10'd0 || vif_s.row !== 10'd0) begin fails++; $display("FAIL midrst_pos got %0d,%0d exp 0,0", vif_s.row, vif_s.col); end
        tests++; if (vif_s.rgb !== 3'b000) begin fails++; $display("FAIL midrst_rgb got %b exp 000", vif_s.rgb); end
        tests++; if (vif_s.pixel_tick !== 1'b0 || vif_s.frame_start !== 1'b0) begin fails++; $display("FAIL midrst_pulses got %b%b exp 00", vif_s.pixel_tick, vif_s.frame_start); end
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (vif_s.pixel_tick !== 1'b1 || vif_s.col !== 10'd0) begin fails++; $display("FAIL restart_tick got tick %b col %0d exp 1,0", vif_s.pixel_tick, vif_s.col); end
        @(posedge clk); #1;
        tests++; if (vif_s.col !== 10'd1) begin fails++; $display("FAIL restart_col got %0d exp 1", vif_s.col); end
        test_model(0, 800, 1'b0);
    endtask

    initial begin
        vif_d.rgb_in = 3'b000;
        vif_s.rgb_in = 3'b000;
        vif_1.rgb_in = 3'b000;
        test_reset();
        test_hline();
        test_model(0, 1600, 1'b0);
        test_model(0, 800, 1'b1);
        test_frame();
        test_model(1, 400, 1'b0);
        test_div1();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got time limit exp completion, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
